// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake and bus signal of the fetch port (i_*), the data
// port (d_*), the external memory port (mem_*) and the two stall outputs, so
// the arbiter and its environment connect through a single port.
//
// Modports:
//   slave  - the arbiter's view. It receives the core requests and memory
//            responses, and drives the ready/rdata/stall/mem command outputs.
//   master - the environment's view. This is the core stages plus the memory,
//            and it is the mirror image of slave.
//
// Parameters: ADDR_W (byte-address width), DATA_W (data width, byte enables
// are DATA_W/8 bits).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch port (read-only)
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ready;
    logic [DATA_W-1:0]     i_rdata;
    // data port (read/write)
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_ready;
    logic [DATA_W-1:0]     d_rdata;
    // external memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    // pipeline stalls
    logic                  stall_if;
    logic                  stall_mem;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_ready, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_ready, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the fetch stage (I-port, read-only)
// and the memory stage (D-port, read/write). At most one memory transaction
// is outstanding at any time. The sequence is IDLE -> CMD -> WAIT -> RESP.
// Each state lasts at least one cycle, so the best case is req at cycle 0 and
// ready at cycle 3.
//
// Ports:
//   clk               core clock, all state on the rising edge
//   reset             asynchronous active-low reset
//   bus               mem_port_arbiter_if.slave: i_*, d_*, mem_*, stall_*
//   perf_conflict_cnt (ARB_PERF_CNT_EN only) cycles in IDLE with both reqs high
//   perf_wait_cnt     (ARB_PERF_CNT_EN only) cycles spent in CMD or WAIT
//
// Optional feature: define ARB_PERF_CNT_EN to add the two saturating
// performance counters. Without it, neither the ports nor the counters exist.
//
// Arbitration: D normally wins, because its instruction is older. Each D win
// while I is waiting bumps a streak counter. Once the streak reaches
// STARVE_LIMIT, I is granted regardless, and the streak returns to 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_conflict_cnt,
    output logic [31:0]        perf_wait_cnt
`endif
);
    localparam int         BE_W         = DATA_W / 8;
    localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic                owner_d_r;     // 1: transaction in flight belongs to D
    logic [3:0]          streak_r;      // consecutive D wins while i_req pending

    // The latched command doubles as the registered mem_* outputs.
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [BE_W-1:0]     mem_be_r;

    logic                i_ready_r;
    logic                d_ready_r;
    logic [DATA_W-1:0]   i_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;

    logic                starve_s;
    logic                grant_d_s;
    logic                grant_i_s;
    logic                gnt_seen_s;
    logic                resp_i_s;
    logic                resp_d_s;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_s = ST_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (bus.mem_gnt) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_CMD;
                end
            end
            // A response coincident with the grant is seen in CMD and never
            // reaches this state, which enforces memory latency >= 1.
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: grant selection, command retirement, response capture
    always_comb begin
        starve_s   = (streak_r == STREAK_LIMIT);
        grant_d_s  = 1'b0;
        grant_i_s  = 1'b0;
        gnt_seen_s = 1'b0;
        resp_i_s   = 1'b0;
        resp_d_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // D yields only when I is actually waiting and starved.
                if (bus.d_req && !(bus.i_req && starve_s)) begin
                    grant_d_s = 1'b1;
                end else if (bus.i_req) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_d_s = 1'b0;
                    grant_i_s = 1'b0;
                end
            end
            ST_CMD:  gnt_seen_s = bus.mem_gnt;
            ST_WAIT: begin
                resp_d_s = bus.mem_rvalid & owner_d_r;
                resp_i_s = bus.mem_rvalid & ~owner_d_r;
            end
            ST_RESP: gnt_seen_s = 1'b0;
            default: gnt_seen_s = 1'b0;
        endcase
    end

    // Command latch: load the winner's fields, and hold mem_req until granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_d_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= {BE_W{1'b0}};
        end else if (grant_d_s) begin
            owner_d_r   <= 1'b1;
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.d_we;
            mem_addr_r  <= bus.d_addr;
            mem_wdata_r <= bus.d_we ? bus.d_wdata : {DATA_W{1'b0}};
            mem_be_r    <= bus.d_we ? bus.d_be : {BE_W{1'b1}};
        end else if (grant_i_s) begin
            owner_d_r   <= 1'b0;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= bus.i_addr;
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= {BE_W{1'b1}};
        end else if (gnt_seen_s) begin
            mem_req_r   <= 1'b0;
        end
    end

    // Starvation streak: counts D wins over a pending fetch, cleared by an I win
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_r <= 4'd0;
        end else if (grant_i_s) begin
            streak_r <= 4'd0;
        end else if (grant_d_s && bus.i_req && (streak_r != STREAK_LIMIT)) begin
            streak_r <= streak_r + 4'd1;
        end
    end

    // Response registers: the ready is high only in RESP, and rdata holds
    // until the next response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
            i_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r <= {DATA_W{1'b0}};
        end else begin
            i_ready_r <= resp_i_s;
            d_ready_r <= resp_d_s;
            if (resp_i_s) begin
                i_rdata_r <= bus.mem_rdata;
            end
            if (resp_d_s) begin
                // a write ack carries no data for the requester
                d_rdata_r <= mem_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
    logic [31:0] conflict_cnt_r;
    logic [31:0] wait_cnt_r;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt_r <= 32'd0;
            wait_cnt_r     <= 32'd0;
        end else begin
            if ((state_r == ST_IDLE) && bus.i_req && bus.d_req && (conflict_cnt_r != CNT_MAX)) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end
            if (((state_r == ST_CMD) || (state_r == ST_WAIT)) && (wait_cnt_r != CNT_MAX)) begin
                wait_cnt_r <= wait_cnt_r + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = conflict_cnt_r;
    assign perf_wait_cnt     = wait_cnt_r;
`endif

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;
    assign bus.i_ready   = i_ready_r;
    assign bus.d_ready   = d_ready_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    // The stalls are combinational, so a requester unfreezes in its ready cycle.
    assign bus.stall_if  = bus.i_req & ~i_ready_r;
    assign bus.stall_mem = bus.d_req & ~d_ready_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench. Stimulus pushes requests into per-port requester queues.
// It also pushes the hand-computed expected memory commands and responses.
// Requester processes hold req until ready. A memory model grants after
// gnt_delay cycles and responds resp_delay+1 cycles after the grant. A monitor
// compares the DUT's commands and responses against the queues.
// Read data rule of the memory model: address 0x4 returns 0x00200113, and any
// other address returns addr ^ 0x5A5A0000. A write ack carries 0xFFFFFFFF, so
// a non-zero store rdata is caught.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed { logic is_d; logic [31:0] rdata; } resp_t;
    typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_wait_cnt     (perf_wait_cnt)
`endif
    );

    resp_t        exp_q[$];
    cmd_t         cmd_q[$];
    logic [31:0]  i_q[$];
    cmd_t         d_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_delay = 0;
    int resp_delay = 0;
    int i_start_cyc = 0;
    int i_ready_cyc = 0;
    int d_ready_cyc = 0;
    int stall_if_cnt = 0;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h0020_0113;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_cmd(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
        cmd_t c;
        c.addr = a; c.we = we; c.wdata = wd; c.be = be;
        cmd_q.push_back(c);
    endtask

    task automatic exp_resp(input logic is_d, input logic [31:0] rd);
        resp_t r;
        r.is_d = is_d; r.rdata = rd;
        exp_q.push_back(r);
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        cmd_t c;
        c.addr = a; c.we = we; c.wdata = wd; c.be = be;
        d_q.push_back(c);
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0) && n < max) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s_timeout: %0d responses pending, expected 0", name, exp_q.size());
            exp_q.delete(); cmd_q.delete(); i_q.delete(); d_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ctl"}, 80'({bus.mem_req, bus.mem_we, bus.mem_be, bus.i_ready, bus.d_ready,
                                   bus.stall_if, bus.stall_mem}), 80'(0));
        check({name, "_addr_wdata"}, 80'({bus.mem_addr, bus.mem_wdata}), 80'(0));
        check({name, "_rdata"}, 80'({bus.i_rdata, bus.d_rdata}), 80'(0));
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // fetch requester
    initial begin
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                bus.i_req = 1'b0;
            end else if (!bus.i_req || bus.i_ready) begin
                if (i_q.size() != 0) begin
                    bus.i_req = 1'b1; bus.i_addr = i_q.pop_front(); i_start_cyc = cyc;
                end else begin
                    bus.i_req = 1'b0;
                end
            end
        end
    end

    // data requester
    initial begin
        cmd_t c;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_be = 4'h0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                bus.d_req = 1'b0;
            end else if (!bus.d_req || bus.d_ready) begin
                if (d_q.size() != 0) begin
                    c = d_q.pop_front();
                    bus.d_req = 1'b1; bus.d_we = c.we; bus.d_addr = c.addr; bus.d_wdata = c.wdata; bus.d_be = c.be;
                end else begin
                    bus.d_req = 1'b0;
                end
            end
        end
    end

    // memory model
    initial begin
        int wcnt; int pcnt; logic pend; logic pwe; logic [31:0] paddr;
        wcnt = 0; pcnt = 0; pend = 1'b0; pwe = 1'b0; paddr = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.mem_gnt = 1'b0;
            if (pend) begin
                if (pcnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = pwe ? 32'hFFFF_FFFF : model_rdata(paddr);
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            if (bus.mem_req) begin
                if (wcnt >= gnt_delay) begin
                    bus.mem_gnt = 1'b1; pend = 1'b1; pcnt = resp_delay;
                    paddr = bus.mem_addr; pwe = bus.mem_we; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // monitor
    initial forever begin
        resp_t e; resp_t a; cmd_t c;
        @(negedge clk);
        if (reset) begin
            checks++;
            if ((!bus.i_req && bus.stall_if) || (!bus.d_req && bus.stall_mem)) begin
                errors++;
                $display("FAIL stall_without_req: stall_if=%b stall_mem=%b i_req=%b d_req=%b expected no stall",
                         bus.stall_if, bus.stall_mem, bus.i_req, bus.d_req);
            end
            if (bus.stall_if) stall_if_cnt++;
            if (bus.mem_req) begin
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: mem_req=1 addr=%h, expected no command", bus.mem_addr);
                end else begin
                    c = cmd_q[0];
                    check("mem_cmd",
                          80'({bus.mem_addr, bus.mem_we, bus.mem_we ? bus.mem_wdata : 32'h0, bus.mem_be}),
                          80'({c.addr, c.we, c.we ? c.wdata : 32'h0, c.be}));
                    if (bus.mem_gnt) void'(cmd_q.pop_front());
                end
            end
            if (bus.i_ready || bus.d_ready) begin
                if (bus.i_ready) i_ready_cyc = cyc;
                if (bus.d_ready) d_ready_cyc = cyc;
                if (exp_q.size() == 0 || (bus.i_ready && bus.d_ready)) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: i_ready=%b d_ready=%b, expected at most one expected pulse",
                             bus.i_ready, bus.d_ready);
                end else begin
                    e = exp_q.pop_front();
                    a.is_d = bus.d_ready;
                    a.rdata = bus.d_ready ? bus.d_rdata : bus.i_rdata;
                    check("response", 80'(a), 80'(e));
                end
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // stimulus
    initial begin
        int n;
        logic saw;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // lone fetch, zero-wait memory
        stall_if_cnt = 0;
        exp_cmd(32'h4, 1'b0, 32'h0, 4'hF);
        exp_resp(1'b0, 32'h0020_0113);
        i_q.push_back(32'h4);
        wait_done("lone_fetch", 50);
        check("lone_fetch_latency", 80'(i_ready_cyc - i_start_cyc), 80'(3));
        check("lone_fetch_stall_cycles", 80'(stall_if_cnt), 80'(3));
`ifdef ARB_PERF_CNT_EN
        check("perf_after_fetch", 80'({perf_conflict_cnt, perf_wait_cnt}), 80'({32'd0, 32'd2}));
`endif

        // conflict: D load (be ignored for reads) beats the fetch
        exp_cmd(32'h100, 1'b0, 32'h0, 4'hF);
        exp_cmd(32'h8, 1'b0, 32'h0, 4'hF);
        exp_resp(1'b1, 32'h5A5A_0100);
        exp_resp(1'b0, 32'h5A5A_0008);
        req_d(1'b0, 32'h100, 32'h0, 4'b0001);
        i_q.push_back(32'h8);
        wait_done("conflict", 60);
        check("conflict_i_after_d", 80'(i_ready_cyc - d_ready_cyc), 80'(4));
`ifdef ARB_PERF_CNT_EN
        check("perf_after_conflict", 80'({perf_conflict_cnt, perf_wait_cnt}), 80'({32'd1, 32'd6}));
`endif

        // starvation: 4 D wins, forced I, streak cleared so D wins twice more
        for (int k = 0; k < 6; k++) req_d(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF);
        i_q.push_back(32'h10);
        i_q.push_back(32'h14);
        for (int k = 0; k < 4; k++) begin
            exp_cmd(32'h200 + 32'(4 * k), 1'b0, 32'h0, 4'hF);
            exp_resp(1'b1, 32'h5A5A_0200 + 32'(4 * k));
        end
        exp_cmd(32'h10, 1'b0, 32'h0, 4'hF);  exp_resp(1'b0, 32'h5A5A_0010);
        exp_cmd(32'h210, 1'b0, 32'h0, 4'hF); exp_resp(1'b1, 32'h5A5A_0210);
        exp_cmd(32'h214, 1'b0, 32'h0, 4'hF); exp_resp(1'b1, 32'h5A5A_0214);
        exp_cmd(32'h14, 1'b0, 32'h0, 4'hF);  exp_resp(1'b0, 32'h5A5A_0014);
        wait_done("starvation", 200);

        // store with grant delayed 3 cycles; mem_* checked each waiting cycle
        gnt_delay = 3;
        exp_cmd(32'h40, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        exp_resp(1'b1, 32'h0);
        req_d(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011);
        wait_done("store", 60);
        gnt_delay = 0;

        // reset while in WAIT; the stale response arrives after release
        resp_delay = 4;
        exp_cmd(32'h8, 1'b0, 32'h0, 4'hF);
        i_q.push_back(32'h8);
        n = 0; saw = 1'b0;
        while (!saw && n < 30) begin
            @(negedge clk);
            saw = bus.mem_gnt;
            n++;
        end
        check("reset_test_gnt_seen", 80'(saw), 80'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check_quiet("after_reset_mid_wait");
        resp_delay = 0;

        // the arbiter must be usable again from IDLE
        exp_cmd(32'hC, 1'b0, 32'h0, 4'hF);
        exp_resp(1'b0, 32'h5A5A_000C);
        i_q.push_back(32'hC);
        wait_done("post_reset_fetch", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
